pcs_tx_ordered_set: RTL and testbench

- Transmit-side ordered-set controller for the 1000BASE-X PCS.
- Each GTX_CLK slot, decides what the 8b/10b code-group encoder sends, based on GMII TXD/TX_EN/TX_ER: /I2/ idle, /S/, data, /V/, /T/, /R/.
- Owns even/odd slot alignment (tx_even), the transmit-side counterpart of rxeven used by the receive synchronization FSM.
- Drives the encoder's symbol inputs; loops back through the receive path in the block-level bench.

---
 rtl/pcs_pkg.sv | 24 ++
 rtl/pcs_tx_ordered_set_if.sv | 25 ++
 rtl/pcs_tx_ordered_set.sv | 111 +++++++++++
 tb/tb_pcs_tx_ordered_set.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// Shared 1000BASE-X PCS definitions: 8b/10b special code-group octets and the
// transmit ordered-set FSM state encoding.
`timescale 1ns/1ps
package pcs_pkg;

    localparam logic [7:0] K28_5   = 8'hBC;
    localparam logic [7:0] D16_2   = 8'h50;
    localparam logic [7:0] K27_7_S = 8'hFB;
    localparam logic [7:0] K29_7_T = 8'hFD;
    localparam logic [7:0] K23_7_R = 8'hF7;
    localparam logic [7:0] K30_7_V = 8'hFE;

    // Each state names the code-group being sent in the current slot.
    typedef enum logic [2:0] {
        IDLE_K,
        IDLE_D,
        START,
        DATA,
        END_T,
        END_R,
        END_R2
    } tx_state_t;

endpackage

// File: rtl/pcs_tx_ordered_set_if.sv
// GMII transmit side plus encoder-facing code-group outputs of the PCS ordered-set controller.
`timescale 1ns/1ps
interface pcs_tx_ordered_set_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       TXD;
    logic             TX_EN;
    logic             TX_ER;
    logic             xmit_data;
    logic [7:0]       tx_sym;
    logic             tx_is_k;
    logic             tx_even;
    logic             transmitting;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output TXD, TX_EN, TX_ER, xmit_data,
        input  tx_sym, tx_is_k, tx_even, transmitting, frame_cnt
    );

    modport slave (
        input  TXD, TX_EN, TX_ER, xmit_data,
        output tx_sym, tx_is_k, tx_even, transmitting, frame_cnt
    );
endinterface

// File: rtl/pcs_tx_ordered_set.sv
// 1000BASE-X PCS transmit ordered-set controller: picks /I2/, /S/, data, /V/, /T/, /R/
// for each GTX_CLK slot and keeps frame boundaries aligned to even slots.
`timescale 1ns/1ps
module pcs_tx_ordered_set
    import pcs_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic                 GTX_CLK,
    input logic                 mr_main_reset,
    pcs_tx_ordered_set_if.slave bus
);

    tx_state_t        state;
    logic [7:0]       sym_q;
    logic             k_q;
    logic             even_q;
    logic             tx_q;
    logic [CNT_W-1:0] cnt_q;

    // Every register holds the value for the slot currently on the wire, so the
    // decision made at an edge uses the GMII inputs of the slot that just ended.
    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state  <= IDLE_D;
            sym_q  <= D16_2;
            k_q    <= 1'b0;
            even_q <= 1'b0;
            tx_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            even_q <= ~even_q;
            case (state)
                IDLE_K: begin
                    state <= IDLE_D;
                    sym_q <= D16_2;
                    k_q   <= 1'b0;
                    tx_q  <= 1'b0;
                end
                IDLE_D: begin
                    if (bus.TX_EN && bus.xmit_data) begin
                        state <= START;
                        sym_q <= K27_7_S;
                        k_q   <= 1'b1;
                        tx_q  <= 1'b1;
                        if (cnt_q != '1) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        state <= IDLE_K;
                        sym_q <= K28_5;
                        k_q   <= 1'b1;
                        tx_q  <= 1'b0;
                    end
                end
                START, DATA: begin
                    if (bus.TX_EN) begin
                        state <= DATA;
                        sym_q <= bus.TX_ER ? K30_7_V : bus.TXD;
                        k_q   <= bus.TX_ER;
                    end else begin
                        state <= END_T;
                        sym_q <= K29_7_T;
                        k_q   <= 1'b1;
                    end
                end
                END_T: begin
                    state <= END_R;
                    sym_q <= K23_7_R;
                    k_q   <= 1'b1;
                end
                END_R: begin
                    // Carrier extension holds /R/; otherwise pad so idle resumes on an even slot.
                    if (!bus.TX_EN && bus.TX_ER) begin
                        state <= END_R;
                        sym_q <= K23_7_R;
                        k_q   <= 1'b1;
                    end else if (!even_q) begin
                        state <= IDLE_K;
                        sym_q <= K28_5;
                        k_q   <= 1'b1;
                        tx_q  <= 1'b0;
                    end else begin
                        state <= END_R2;
                        sym_q <= K23_7_R;
                        k_q   <= 1'b1;
                    end
                end
                END_R2: begin
                    state <= IDLE_K;
                    sym_q <= K28_5;
                    k_q   <= 1'b1;
                    tx_q  <= 1'b0;
                end
                default: begin
                    state <= IDLE_K;
                    sym_q <= K28_5;
                    k_q   <= 1'b1;
                    tx_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_sym       = sym_q;
    assign bus.tx_is_k      = k_q;
    assign bus.tx_even      = even_q;
    assign bus.transmitting = tx_q;
    assign bus.frame_cnt    = cnt_q;

endmodule

// File: tb/tb_pcs_tx_ordered_set.sv
// Self-checking bench for pcs_tx_ordered_set: directed vector table, directed corner
// sequences and randomized sessions scored against a slot-stream reference model.
`timescale 1ns/1ps
module tb_pcs_tx_ordered_set;

    localparam int CNT_W = 4;
    localparam int MAXN  = 700;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pcs_tx_ordered_set_if #(.CNT_W(CNT_W)) bus();

    pcs_tx_ordered_set #(.CNT_W(CNT_W)) dut (
        .GTX_CLK       (clk),
        .mr_main_reset (rst_n),
        .bus           (bus.slave)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct packed {
        logic             en;
        logic             er;
        logic [7:0]       d;
        logic [7:0]       es;
        logic             ek;
        logic             eev;
        logic             etx;
        logic [CNT_W-1:0] ecnt;
    } vec_t;

    vec_t tbl[22];

    // Per-slot stimulus, observed outputs and model expectations for a session.
    logic             in_en [MAXN+1];
    logic             in_er [MAXN+1];
    logic             in_x  [MAXN+1];
    logic [7:0]       in_d  [MAXN+1];
    logic [7:0]       o_sym [MAXN+1];
    logic             o_k   [MAXN+1];
    logic             o_ev  [MAXN+1];
    logic             o_tx  [MAXN+1];
    logic [CNT_W-1:0] o_cnt [MAXN+1];
    logic [7:0]       e_sym [MAXN+1];
    logic             e_k   [MAXN+1];
    logic             e_ev  [MAXN+1];
    logic             e_tx  [MAXN+1];
    logic [CNT_W-1:0] e_cnt [MAXN+1];

    function automatic vec_t mk(input logic en, input logic er, input logic [7:0] d,
                                input logic [7:0] es, input logic ek, input logic eev,
                                input logic etx, input int ecnt);
        vec_t v;
        v.en = en; v.er = er; v.d = d;
        v.es = es; v.ek = ek; v.eev = eev; v.etx = etx;
        v.ecnt = ecnt[CNT_W-1:0];
        return v;
    endfunction

    task automatic applyStimulus(input logic en, input logic er, input logic [7:0] d, input logic x);
        bus.TX_EN     = en;
        bus.TX_ER     = er;
        bus.TXD       = d;
        bus.xmit_data = x;
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [7:0] sym, input logic k, input logic ev,
                               input logic tx, input logic [CNT_W-1:0] cnt,
                               input logic [7:0] es, input logic ek, input logic eev,
                               input logic etx, input logic [CNT_W-1:0] ecnt);
        testsRun++;
        if ({sym, k, ev, tx, cnt} !== {es, ek, eev, etx, ecnt}) begin
            testsFailed++;
            $display("[TB] FAIL %s[%0d]: got sym=%h k=%b even=%b tx=%b cnt=%0d, expected sym=%h k=%b even=%b tx=%b cnt=%0d",
                     name, idx, sym, k, ev, tx, cnt, es, ek, eev, etx, ecnt);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic emit(input int t, input int n, input logic [7:0] sym, input logic k,
                        input logic tx, input int cnt);
        if (t <= n) begin
            e_sym[t] = sym;
            e_k[t]   = k;
            e_tx[t]  = tx;
            e_cnt[t] = cnt[CNT_W-1:0];
            e_ev[t]  = (t % 2 == 1);
        end
    endtask

    // Walks the recorded input stream and writes out the code-group stream the PCS
    // rules demand; slot 0 is the reset slot, and slot t is even exactly when t is odd.
    task automatic buildModel(input int n);
        int t;
        int cnt;
        t = 0;
        cnt = 0;
        e_sym[0] = 8'h50; e_k[0] = 1'b0; e_ev[0] = 1'b0; e_tx[0] = 1'b0; e_cnt[0] = '0;
        while (t < n) begin
            if (in_en[t] && in_x[t]) begin
                t++;
                if (cnt < CMAX) cnt++;
                emit(t, n, 8'hFB, 1'b1, 1'b1, cnt);
                while (t < n && in_en[t]) begin
                    t++;
                    emit(t, n, in_er[t-1] ? 8'hFE : in_d[t-1], in_er[t-1], 1'b1, cnt);
                end
                t++; emit(t, n, 8'hFD, 1'b1, 1'b1, cnt);
                t++; emit(t, n, 8'hF7, 1'b1, 1'b1, cnt);
                while (t < n && !in_en[t] && in_er[t]) begin
                    t++; emit(t, n, 8'hF7, 1'b1, 1'b1, cnt);
                end
                if (t % 2 == 1) begin
                    t++; emit(t, n, 8'hF7, 1'b1, 1'b1, cnt);
                end
            end
            t++; emit(t, n, 8'hBC, 1'b1, 1'b0, cnt);
            t++; emit(t, n, 8'h50, 1'b0, 1'b0, cnt);
        end
    endtask

    task automatic runSession(input string name, input int n);
        doReset();
        for (int s = 0; s < n; s++) begin
            o_sym[s] = bus.tx_sym; o_k[s] = bus.tx_is_k; o_ev[s] = bus.tx_even;
            o_tx[s] = bus.transmitting; o_cnt[s] = bus.frame_cnt;
            applyStimulus(in_en[s], in_er[s], in_d[s], in_x[s]);
            @(posedge clk);
            @(negedge clk);
        end
        o_sym[n] = bus.tx_sym; o_k[n] = bus.tx_is_k; o_ev[n] = bus.tx_even;
        o_tx[n] = bus.transmitting; o_cnt[n] = bus.frame_cnt;
        buildModel(n);
        for (int s = 0; s <= n; s++) begin
            checkOutput(name, s, o_sym[s], o_k[s], o_ev[s], o_tx[s], o_cnt[s],
                        e_sym[s], e_k[s], e_ev[s], e_tx[s], e_cnt[s]);
        end
    endtask

    task automatic clearInputs(input logic x);
        for (int s = 0; s <= MAXN; s++) begin
            in_en[s] = 1'b0; in_er[s] = 1'b0; in_x[s] = x; in_d[s] = 8'h00;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic prevEn;
        logic x;

        // Rows: inputs driven in slot i, expected outputs in slot i+1.
        tbl[0]  = mk(0, 0, 8'h00, 8'hBC, 1, 1, 0, 0);
        tbl[1]  = mk(0, 0, 8'h00, 8'h50, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 8'h55, 8'hFB, 1, 1, 1, 1);
        tbl[3]  = mk(1, 0, 8'hD5, 8'hD5, 0, 0, 1, 1);
        tbl[4]  = mk(1, 0, 8'hAA, 8'hAA, 0, 1, 1, 1);
        tbl[5]  = mk(1, 0, 8'hBB, 8'hBB, 0, 0, 1, 1);
        tbl[6]  = mk(0, 0, 8'h00, 8'hFD, 1, 1, 1, 1);
        tbl[7]  = mk(0, 0, 8'h00, 8'hF7, 1, 0, 1, 1);
        tbl[8]  = mk(0, 0, 8'h00, 8'hBC, 1, 1, 0, 1);
        tbl[9]  = mk(0, 0, 8'h00, 8'h50, 0, 0, 0, 1);
        tbl[10] = mk(1, 0, 8'h11, 8'hFB, 1, 1, 1, 2);
        tbl[11] = mk(1, 0, 8'h22, 8'h22, 0, 0, 1, 2);
        tbl[12] = mk(1, 1, 8'h33, 8'hFE, 1, 1, 1, 2);
        tbl[13] = mk(1, 0, 8'h44, 8'h44, 0, 0, 1, 2);
        tbl[14] = mk(1, 0, 8'h66, 8'h66, 0, 1, 1, 2);
        tbl[15] = mk(0, 0, 8'h00, 8'hFD, 1, 0, 1, 2);
        tbl[16] = mk(0, 0, 8'h00, 8'hF7, 1, 1, 1, 2);
        tbl[17] = mk(0, 0, 8'h00, 8'hF7, 1, 0, 1, 2);
        tbl[18] = mk(0, 0, 8'h00, 8'hBC, 1, 1, 0, 2);
        tbl[19] = mk(1, 1, 8'h77, 8'h50, 0, 0, 0, 2);
        tbl[20] = mk(0, 1, 8'h00, 8'hBC, 1, 1, 0, 2);
        tbl[21] = mk(0, 0, 8'h00, 8'h50, 0, 0, 0, 2);

        doReset();
        checkOutput("reset", 0, bus.tx_sym, bus.tx_is_k, bus.tx_even, bus.transmitting,
                    bus.frame_cnt, 8'h50, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 22; i++) begin
            applyStimulus(tbl[i].en, tbl[i].er, tbl[i].d, 1'b1);
            @(posedge clk);
            @(negedge clk);
            checkOutput("table", i, bus.tx_sym, bus.tx_is_k, bus.tx_even, bus.transmitting,
                        bus.frame_cnt, tbl[i].es, tbl[i].ek, tbl[i].eev, tbl[i].etx, tbl[i].ecnt);
        end

        // Carrier extension after /T/.
        clearInputs(1'b1);
        for (int s = 0; s < 3; s++) begin
            in_en[s] = 1'b1; in_d[s] = 8'h55 + 8'(s);
        end
        for (int s = 4; s < 8; s++) in_er[s] = 1'b1;
        runSession("extend", 16);

        // Frames blocked while xmit_data is low.
        clearInputs(1'b0);
        for (int s = 2; s < 14; s++) in_en[s] = 1'b1;
        runSession("no_xmit", 20);

        // Random traffic long enough to saturate the narrow frame counter.
        prevEn = 1'b0;
        x = 1'b1;
        for (int s = 0; s <= 600; s++) begin
            if ($urandom_range(39) == 0) x = ~x;
            in_en[s] = prevEn ? ($urandom_range(5) != 0) : ($urandom_range(2) == 0);
            in_er[s] = ($urandom_range(7) == 0);
            in_d[s]  = 8'($urandom);
            in_x[s]  = x;
            prevEn   = in_en[s];
        end
        runSession("random", 600);

        // Reset asserted in the middle of a frame takes effect without a clock edge.
        doReset();
        applyStimulus(1'b1, 1'b0, 8'h12, 1'b1);
        @(posedge clk); @(negedge clk);
        applyStimulus(1'b1, 1'b0, 8'h34, 1'b1);
        @(posedge clk); @(negedge clk);
        checkOutput("mid_frame", 2, bus.tx_sym, bus.tx_is_k, bus.tx_even, bus.transmitting,
                    bus.frame_cnt, 8'h34, 1'b0, 1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 8'h56, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 0, bus.tx_sym, bus.tx_is_k, bus.tx_even, bus.transmitting,
                    bus.frame_cnt, 8'h50, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        checkOutput("after_reset", 1, bus.tx_sym, bus.tx_is_k, bus.tx_even, bus.transmitting,
                    bus.frame_cnt, 8'hBC, 1'b1, 1'b1, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
